// File: rtl/alu_operand_issue.sv
// Operand issue stage: decodes instruction words, reads the register file and holds one
// registered operand slot for alu_math. Optional pending-register interlock: SCOREBOARD_EN.
package simple_processor_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [3:0] FUNC_ADD  = 4'h0;
  localparam logic [3:0] FUNC_SUB  = 4'h1;
  localparam logic [3:0] FUNC_ADDI = 4'h2;
endpackage

module alu_operand_issue
  import simple_processor_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int FUNC_W   = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [31:0]           instr_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  output logic [5:0]            imm_o,
  output logic [FUNC_W-1:0]     func_o,
  output logic [4:0]            rd_o,
  output logic                  op_valid_o,
  input  logic                  op_ready_i,
  input  logic                  wb_en_i,
  input  logic [4:0]            wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Ready never waits on valid, except that the interlock only stalls a presented instruction.

  logic [FUNC_W-1:0]     w_func;
  logic [4:0]            w_rd;
  logic [4:0]            w_rs1;
  logic [4:0]            w_rs2;
  logic [5:0]            w_imm;
  logic                  w_unused_bits;
  logic [DATA_WIDTH-1:0] w_rs1_data;
  logic [DATA_WIDTH-1:0] w_rs2_data;
  logic                  w_hazard;
  logic                  w_accept;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_rs1_data;
  logic [DATA_WIDTH-1:0] r_rs2_data;
  logic [5:0]            r_imm;
  logic [FUNC_W-1:0]     r_func;
  logic [4:0]            r_rd;
  logic                  r_op_valid;

  assign w_func        = FUNC_W'(instr_i[31:28]);
  assign w_rd          = instr_i[27:23];
  assign w_rs1         = instr_i[22:18];
  assign w_rs2         = instr_i[17:13];
  assign w_imm         = instr_i[5:0];
  assign w_unused_bits = ^instr_i[12:6];

  // Same-cycle writeback is forwarded so a dependent instruction needs no extra bubble.
  always_comb begin
    w_rs1_data = '0;
    if (w_rs1 != 5'd0) begin
      if (wb_en_i && (wb_addr_i == w_rs1)) w_rs1_data = wb_data_i;
      else                                 w_rs1_data = r_regs[w_rs1];
    end
  end

  always_comb begin
    w_rs2_data = '0;
    if (w_rs2 != 5'd0) begin
      if (wb_en_i && (wb_addr_i == w_rs2)) w_rs2_data = wb_data_i;
      else                                 w_rs2_data = r_regs[w_rs2];
    end
  end

`ifdef SCOREBOARD_EN
  localparam logic [FUNC_W-1:0] LP_ADDI = FUNC_W'(FUNC_ADDI);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_pend_eff;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_accept && (w_rd != 5'd0))     w_set[w_rd]      = 1'b1;
    if (wb_en_i && (wb_addr_i != 5'd0)) w_clr[wb_addr_i] = 1'b1;
  end

  // Bits cleared by this cycle's writeback are covered by the bypass path.
  assign w_pend_eff = r_pending & ~w_clr;
  assign w_hazard   = instr_valid_i &
                      (w_pend_eff[w_rs1] | ((w_func != LP_ADDI) & w_pend_eff[w_rs2]));

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr) | w_set;
  end
`else
  assign w_hazard = 1'b0;
`endif

  assign instr_ready_o = (~r_op_valid | op_ready_i) & ~w_hazard;
  assign w_accept      = instr_valid_i & instr_ready_o;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (wb_en_i && (wb_addr_i != 5'd0)) begin
      r_regs[wb_addr_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_op_valid <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_func     <= '0;
      r_rd       <= '0;
    end else if (w_accept) begin
      r_op_valid <= 1'b1;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= w_imm;
      r_func     <= w_func;
      r_rd       <= w_rd;
    end else if (op_ready_i) begin
      r_op_valid <= 1'b0;
    end
  end

  assign op_valid_o = r_op_valid;
  assign rs1_data_o = r_rs1_data;
  assign rs2_data_o = r_rs2_data;
  assign imm_o      = r_imm;
  assign func_o     = r_func;
  assign rd_o       = r_rd;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for alu_operand_issue: stimulus pushes expected slot contents, a negedge
// monitor pops and compares on every consumed slot. Interlock cases run with SCOREBOARD_EN.
module tb_alu_operand_issue;
  localparam logic [3:0] ADD  = 4'h0;
  localparam logic [3:0] SUB  = 4'h1;
  localparam logic [3:0] ADDI = 4'h2;

  logic        clk_i;
  logic        arst_i;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic [5:0]  imm_o;
  logic [3:0]  func_o;
  logic [4:0]  rd_o;
  logic        op_valid_o;
  logic        op_ready_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;

  int n_tests = 0;
  int n_fail  = 0;

  // {rs1, rs2, imm, func, rd}
  logic [78:0] exp_q[$];

  alu_operand_issue dut (
    .clk_i(clk_i), .arst_i(arst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .imm_o(imm_o), .func_o(func_o), .rd_o(rd_o), .op_valid_o(op_valid_o),
    .op_ready_i(op_ready_i), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i)
  );

  // Clock and reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] mk(input logic [3:0] f, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [5:0] imm);
    return {f, rd, rs1, rs2, 7'h55, imm};
  endfunction

  function automatic logic [78:0] pack_exp(input logic [31:0] ins, input logic [31:0] e1,
                                           input logic [31:0] e2);
    return {e1, e2, ins[5:0], ins[31:28], ins[27:23]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every consumed slot must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!arst_i && op_valid_o && op_ready_i) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL slot_unexpected: got rs1=%h rd=%0d with empty queue", rs1_data_o, rd_o);
      end else begin
        logic [78:0] e;
        e = exp_q.pop_front();
        if ({rs1_data_o, rs2_data_o, imm_o, func_o, rd_o} !== e) begin
          n_fail++;
          $display("FAIL slot: got rs1=%h rs2=%h imm=%h func=%h rd=%0d expected rs1=%h rs2=%h imm=%h func=%h rd=%0d",
                   rs1_data_o, rs2_data_o, imm_o, func_o, rd_o,
                   e[78:47], e[46:15], e[14:9], e[8:5], e[4:0]);
        end
      end
    end
  end

  // Driver tasks: entered and left at posedge+2.
  task automatic issue(input logic [31:0] ins, input logic [31:0] e1, input logic [31:0] e2);
    int cyc;
    instr_i       = ins;
    instr_valid_i = 1'b1;
    exp_q.push_back(pack_exp(ins, e1, e2));
    cyc = 0;
    forever begin
      @(negedge clk_i);
      if (instr_ready_o) break;
      cyc++;
      if (cyc > 50) begin
        chk("issue_timeout", 32'(instr_ready_o), 32'd1);
        break;
      end
    end
    @(posedge clk_i); #2;
    instr_valid_i = 1'b0;
    chk("latency_valid", 32'(op_valid_o), 32'd1);
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en_i   = 1'b1;
    wb_addr_i = a;
    wb_data_i = d;
    @(posedge clk_i); #2;
    wb_en_i = 1'b0;
  endtask

  initial begin
    arst_i = 1'b1; instr_i = '0; instr_valid_i = 1'b0; op_ready_i = 1'b1;
    wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    repeat (2) @(posedge clk_i);
    #2 arst_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    chk("rst_op_valid", 32'(op_valid_o), 32'd0);
    chk("rst_rs1", rs1_data_o, 32'd0);
    chk("rst_rs2", rs2_data_o, 32'd0);
    chk("rst_rd_imm_func", {17'd0, rd_o, imm_o, func_o}, 32'd0);
    chk("rst_instr_ready", 32'(instr_ready_o), 32'd1);
    @(posedge clk_i); #2;

    // Basic issue from x0
    issue(mk(ADD, 5'd3, 5'd0, 5'd0, 6'h11), 32'd0, 32'd0);

    // Regfile write/read, x0 writes discarded even with same-cycle bypass
    wb(5'd5, 32'h0000_00AA);
    issue(mk(ADD, 5'd10, 5'd5, 5'd0, 6'h3f), 32'h0000_00AA, 32'd0);
    wb_en_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hFFFF_FFFF;
    issue(mk(SUB, 5'd11, 5'd0, 5'd5, 6'h00), 32'd0, 32'h0000_00AA);
    wb_en_i = 1'b0;
    issue(mk(ADD, 5'd11, 5'd0, 5'd0, 6'h01), 32'd0, 32'd0);

    // Same-cycle writeback bypass, then value persists in the regfile
    wb_en_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h1234_5678;
    issue(mk(ADD, 5'd12, 5'd7, 5'd0, 6'h01), 32'h1234_5678, 32'd0);
    wb_en_i = 1'b0;
    issue(mk(SUB, 5'd13, 5'd0, 5'd7, 6'h02), 32'd0, 32'h1234_5678);

    // Downstream back-pressure: slot held, upstream stalled
    issue(mk(ADD, 5'd14, 5'd5, 5'd7, 6'h2a), 32'h0000_00AA, 32'h1234_5678);
    op_ready_i    = 1'b0;
    instr_i       = mk(SUB, 5'd15, 5'd7, 5'd5, 6'h05);
    instr_valid_i = 1'b1;
    exp_q.push_back(pack_exp(instr_i, 32'h1234_5678, 32'h0000_00AA));
    repeat (3) begin
      @(negedge clk_i);
      chk("bp_instr_ready", 32'(instr_ready_o), 32'd0);
      chk("bp_valid_held", 32'(op_valid_o), 32'd1);
      chk("bp_rs1_held", rs1_data_o, 32'h0000_00AA);
      chk("bp_rs2_held", rs2_data_o, 32'h1234_5678);
      chk("bp_rd_imm_held", {21'd0, rd_o, imm_o}, {21'd0, 5'd14, 6'h2a});
      @(posedge clk_i); #2;
    end
    op_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_release_ready", 32'(instr_ready_o), 32'd1);
    @(posedge clk_i); #2;
    instr_valid_i = 1'b0;
    chk("bp_next_valid", 32'(op_valid_o), 32'd1);
    @(posedge clk_i); #2;
    @(negedge clk_i);
    chk("valid_falls", 32'(op_valid_o), 32'd0);
    @(posedge clk_i); #2;

`ifdef SCOREBOARD_EN
    // RAW interlock released in the writeback cycle via bypass
    issue(mk(ADD, 5'd4, 5'd0, 5'd0, 6'h00), 32'd0, 32'd0);
    instr_i       = mk(SUB, 5'd8, 5'd4, 5'd0, 6'h00);
    instr_valid_i = 1'b1;
    exp_q.push_back(pack_exp(instr_i, 32'h0000_0010, 32'd0));
    repeat (2) begin
      @(negedge clk_i);
      chk("sb_stall", 32'(instr_ready_o), 32'd0);
      @(posedge clk_i); #2;
    end
    wb_en_i = 1'b1; wb_addr_i = 5'd4; wb_data_i = 32'h0000_0010;
    @(negedge clk_i);
    chk("sb_release", 32'(instr_ready_o), 32'd1);
    @(posedge clk_i); #2;
    wb_en_i = 1'b0; instr_valid_i = 1'b0;
    chk("sb_release_valid", 32'(op_valid_o), 32'd1);

    // ADDI ignores a pending rs2; SUB does not
    issue(mk(ADD, 5'd6, 5'd0, 5'd0, 6'h00), 32'd0, 32'd0);
    instr_i       = mk(ADDI, 5'd9, 5'd0, 5'd6, 6'h03);
    instr_valid_i = 1'b1;
    exp_q.push_back(pack_exp(instr_i, 32'd0, 32'd0));
    @(negedge clk_i);
    chk("sb_addi_no_stall", 32'(instr_ready_o), 32'd1);
    @(posedge clk_i); #2;
    instr_i = mk(SUB, 5'd9, 5'd0, 5'd6, 6'h00);
    exp_q.push_back(pack_exp(instr_i, 32'd0, 32'h0000_0066));
    @(negedge clk_i);
    chk("sb_sub_rs2_stall", 32'(instr_ready_o), 32'd0);
    @(posedge clk_i); #2;
    wb_en_i = 1'b1; wb_addr_i = 5'd6; wb_data_i = 32'h0000_0066;
    @(negedge clk_i);
    chk("sb_rs2_release", 32'(instr_ready_o), 32'd1);
    @(posedge clk_i); #2;
    wb_en_i = 1'b0; instr_valid_i = 1'b0;
`endif

    // Async reset mid-stall drops the slot and clears regs/pending
    issue(mk(ADD, 5'd4, 5'd5, 5'd0, 6'h00), 32'h0000_00AA, 32'd0);
    op_ready_i    = 1'b0;
    instr_i       = mk(SUB, 5'd16, 5'd4, 5'd4, 6'h00);
    instr_valid_i = 1'b1;
    @(negedge clk_i);
    chk("pre_rst_valid", 32'(op_valid_o), 32'd1);
    #1 arst_i = 1'b1;
    #1;
    chk("arst_valid_drop", 32'(op_valid_o), 32'd0);
    chk("arst_rs1_clear", rs1_data_o, 32'd0);
    chk("arst_rd_clear", 32'(rd_o), 32'd0);
    exp_q.delete();
    @(posedge clk_i); #2;
    arst_i     = 1'b0;
    op_ready_i = 1'b1;
    exp_q.push_back(pack_exp(instr_i, 32'd0, 32'd0));
    @(negedge clk_i);
    chk("arst_pending_clear", 32'(instr_ready_o), 32'd1);
    @(posedge clk_i); #2;
    instr_valid_i = 1'b0;
    chk("arst_issue_valid", 32'(op_valid_o), 32'd1);
    issue(mk(ADD, 5'd17, 5'd5, 5'd7, 6'h00), 32'd0, 32'd0);

    // Drain
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0) break;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
